irq_controller: RTL and testbench

- Memory-mapped interrupt controller on the 8-bit CPU bus.
- Collects raise lines from up to four peripherals (timer, mouse, IR, spare) and presents one interrupt request to the CPU.
- Selects one pending, enabled source by priority and routes the CPU's acknowledge back to that source only.
- Exposes pending, mask and active-vector registers so the interrupt service routine knows which peripheral to service.

---
 rtl/irq_pkg.sv | 29 ++
 rtl/irq_controller_if.sv | 24 ++
 rtl/irq_priority_select.sv | 53 +++++
 rtl/irq_controller.sv | 149 ++++++++++++++
 tb/tb_irq_controller.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// Shared constants, register offsets and FSM encoding for the interrupt controller.
package irq_pkg;

   localparam int unsigned NUM_SRC       = 4;
   localparam int unsigned IDX_W         = 2;
   localparam int unsigned DATA_W        = 8;
   localparam int unsigned OFF_W         = 2;
   localparam int unsigned VEC_VALID_BIT = 7;

   localparam logic [OFF_W-1:0] OFF_PENDING = 2'd0;
   localparam logic [OFF_W-1:0] OFF_MASK    = 2'd1;
   localparam logic [OFF_W-1:0] OFF_VECTOR  = 2'd2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ASSERT = 2'd1,
      ACK    = 2'd2
   } irq_state_e;

   // Vector register image: valid flag in the top bit, source index in the low bits.
   function automatic logic [DATA_W-1:0] make_vector(input logic valid,
                                                     input logic [IDX_W-1:0] idx);
      logic [DATA_W-1:0] v;
      v                = DATA_W'(idx);
      v[VEC_VALID_BIT] = valid;
      return v;
   endfunction

endpackage

// File: rtl/irq_controller_if.sv
// CPU-side address/write strobe and interrupt request/acknowledge handshake.
interface irq_controller_if;
   import irq_pkg::*;

   logic [DATA_W-1:0] BUS_ADDR;
   logic              BUS_WE;
   logic              CPU_IRQ;
   logic              CPU_IRQ_ACK;

   modport master (
      output BUS_ADDR,
      output BUS_WE,
      output CPU_IRQ_ACK,
      input  CPU_IRQ
   );

   modport slave (
      input  BUS_ADDR,
      input  BUS_WE,
      input  CPU_IRQ_ACK,
      output CPU_IRQ
   );

endinterface

// File: rtl/irq_priority_select.sv
// Picks one candidate source by fixed or rotating priority; owns the rotation pointer.
module irq_priority_select
   import irq_pkg::*;
#(
   parameter int unsigned NumSources = NUM_SRC,
   parameter bit          RoundRobin = 1'b0
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [NumSources-1:0] cand_i,
   input  logic                  ack_stb_i,
   input  logic [IDX_W-1:0]      ack_idx_i,
   output logic [IDX_W-1:0]      idx_c_o,
   output logic                  any_c_o
);

   logic [IDX_W-1:0] rr_q;
   logic [IDX_W-1:0] rr_d;
   logic [IDX_W-1:0] start;
   logic [IDX_W-1:0] pos;

   // Pointer moves just past the serviced source so it gets lowest priority next.
   always_comb begin
      rr_d = rr_q;
      if (ack_stb_i) begin
         rr_d = IDX_W'(ack_idx_i + IDX_W'(1));
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         rr_q <= '0;
      end else begin
         rr_q <= rr_d;
      end
   end

   // Scan downward so the first candidate after the start point is the final winner.
   always_comb begin
      start   = RoundRobin ? rr_q : '0;
      idx_c_o = '0;
      any_c_o = 1'b0;
      pos     = '0;
      for (int k = NumSources - 1; k >= 0; k--) begin
         pos = IDX_W'(start + IDX_W'(k));
         if (cand_i[pos]) begin
            idx_c_o = pos;
            any_c_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: edge-captured pending bits, mask, vector
// register and a single CPU request routed back to the serviced peripheral.
module irq_controller
   import irq_pkg::*;
#(
   parameter logic [DATA_W-1:0]  IrqBaseAddr = 8'hF8,
   parameter int unsigned        NumSources  = NUM_SRC,
   parameter logic [NUM_SRC-1:0] InitialMask = 4'b0001,
   parameter bit                 RoundRobin  = 1'b0
) (
   input  logic                  CLK,
   input  logic                  RST,
   irq_controller_if.slave       bus,
   inout  wire  [DATA_W-1:0]     BUS_DATA,
   input  logic [NumSources-1:0] SRC_RAISE,
   output logic [NumSources-1:0] SRC_ACK
);

   logic [NumSources-1:0] raise_q;
   logic [NumSources-1:0] pending_q;
   logic [NumSources-1:0] pending_d;
   logic [NumSources-1:0] mask_q;
   logic [NumSources-1:0] mask_d;
   logic [NumSources-1:0] rise;
   logic [NumSources-1:0] w1c;
   logic [NumSources-1:0] ack_clr;
   logic [NumSources-1:0] cand;
   logic [NumSources-1:0] ack_q;

   logic [DATA_W-1:0]     rdata_q;
   logic [DATA_W-1:0]     rdata_d;
   logic                  rdoe_q;
   logic                  rdoe_d;
   logic [DATA_W-1:0]     addr_off;
   logic [DATA_W-1:0]     wdata;
   logic [OFF_W-1:0]      off;
   logic                  hit;
   logic                  wr_en;
   logic                  rd_en;
   logic                  unused_wdata_hi;

   irq_state_e            state_q;
   logic [IDX_W-1:0]      idx_q;
   logic                  irq_q;
   logic [IDX_W-1:0]      sel_idx;
   logic                  sel_any;

   assign wdata           = BUS_DATA;
   assign unused_wdata_hi = ^wdata[DATA_W-1:NumSources];

   // Address window decode relative to the base.
   always_comb begin
      addr_off = DATA_W'(bus.BUS_ADDR - IrqBaseAddr);
      hit      = (addr_off[DATA_W-1:OFF_W] == '0);
      off      = addr_off[OFF_W-1:0];
      wr_en    = hit & bus.BUS_WE;
      rd_en    = hit & ~bus.BUS_WE;
   end

   // Register next-state: new edges win over both W1C and the ACK-cycle clear.
   always_comb begin
      rise      = SRC_RAISE & ~raise_q;
      w1c       = (wr_en && off == OFF_PENDING) ? wdata[NumSources-1:0] : '0;
      ack_clr   = (state_q == ACK) ? (NumSources'(1) << idx_q) : '0;
      pending_d = (pending_q & ~w1c & ~ack_clr) | rise;
      mask_d    = (wr_en && off == OFF_MASK) ? wdata[NumSources-1:0] : mask_q;
      rdoe_d    = rd_en;
      rdata_d   = '0;
      if (rd_en) begin
         unique case (off)
            OFF_PENDING: rdata_d = DATA_W'(pending_q);
            OFF_MASK:    rdata_d = DATA_W'(mask_q);
            OFF_VECTOR:  rdata_d = make_vector(state_q != IDLE, idx_q);
            default:     rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         raise_q   <= '0;
         pending_q <= '0;
         mask_q    <= InitialMask;
         rdata_q   <= '0;
         rdoe_q    <= 1'b0;
      end else begin
         raise_q   <= SRC_RAISE;
         pending_q <= pending_d;
         mask_q    <= mask_d;
         rdata_q   <= rdata_d;
         rdoe_q    <= rdoe_d;
      end
   end

   assign cand = pending_q & mask_q;

   irq_priority_select #(
      .NumSources (NumSources),
      .RoundRobin (RoundRobin)
   ) u_sel (
      .CLK       (CLK),
      .RST       (RST),
      .cand_i    (cand),
      .ack_stb_i (state_q == ACK),
      .ack_idx_i (idx_q),
      .idx_c_o   (sel_idx),
      .any_c_o   (sel_any)
   );

   // Request FSM; once in ASSERT the latched index is serviced unconditionally.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         idx_q   <= '0;
         irq_q   <= 1'b0;
         ack_q   <= '0;
      end else begin
         ack_q <= '0;
         unique case (state_q)
            IDLE: begin
               if (sel_any) begin
                  state_q <= ASSERT;
                  idx_q   <= sel_idx;
                  irq_q   <= 1'b1;
               end
            end
            ASSERT: begin
               if (bus.CPU_IRQ_ACK) begin
                  state_q <= ACK;
                  irq_q   <= 1'b0;
                  ack_q   <= NumSources'(1) << idx_q;
               end
            end
            ACK: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               irq_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.CPU_IRQ = irq_q;
   assign SRC_ACK     = ack_q;
   assign BUS_DATA    = rdoe_q ? rdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_irq_controller.sv
// Directed vector bench for irq_controller: fixed-priority instance via a cycle table,
// plus a rotating-priority instance exercised with a service-order sequence.
module tb_irq_controller;

   typedef struct {
      logic       rst;
      logic [7:0] addr;
      logic       we;
      logic [7:0] wdata;
      logic [3:0] raise;
      logic       cpu_ack;
      logic       exp_irq;
      logic [3:0] exp_ack;
      logic [7:0] exp_data;
   } vec_t;

   logic       CLK;
   logic       RST;
   logic [3:0] raise0;
   logic [3:0] raise1;
   logic [3:0] ack0;
   logic [3:0] ack1;
   logic       drv0;
   logic [7:0] wdata0;
   wire  [7:0] bus_data0;
   wire  [7:0] bus_data1;

   int checks;
   int failures;
   vec_t vq[$];

   pullup (bus_data0);
   assign bus_data0 = drv0 ? wdata0 : 8'hzz;

   irq_controller_if if0 ();
   irq_controller_if if1 ();

   irq_controller u_dut0 (
      .CLK       (CLK),
      .RST       (RST),
      .bus       (if0),
      .BUS_DATA  (bus_data0),
      .SRC_RAISE (raise0),
      .SRC_ACK   (ack0)
   );

   irq_controller #(
      .InitialMask (4'b1111),
      .RoundRobin  (1'b1)
   ) u_dut1 (
      .CLK       (CLK),
      .RST       (RST),
      .bus       (if1),
      .BUS_DATA  (bus_data1),
      .SRC_RAISE (raise1),
      .SRC_ACK   (ack1)
   );

   initial CLK = 1'b0;
   always #10 CLK = ~CLK;

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s #%0d: actual=%02h required=%02h", nm, idx, act, exp);
      end
   endtask

   task automatic add(input logic rst, input logic [7:0] addr, input logic we, input logic [7:0] wd,
                      input logic [3:0] raise, input logic cack, input logic irq,
                      input logic [3:0] sack, input logic [7:0] data);
      vec_t v;
      v.rst = rst; v.addr = addr; v.we = we; v.wdata = wd; v.raise = raise; v.cpu_ack = cack;
      v.exp_irq = irq; v.exp_ack = sack; v.exp_data = data;
      vq.push_back(v);
   endtask

   initial begin
      int order [5];
      int n;
      logic [3:0] exp_oh;

      checks   = 0;
      failures = 0;
      RST      = 1'b1;
      raise0   = '0;
      raise1   = '0;
      drv0     = 1'b0;
      wdata0   = '0;
      if0.BUS_ADDR = '0; if0.BUS_WE = 1'b0; if0.CPU_IRQ_ACK = 1'b0;
      if1.BUS_ADDR = '0; if1.BUS_WE = 1'b0; if1.CPU_IRQ_ACK = 1'b0;

      //   rst addr  we wdata raise ack | irq sack data   (expected after the clock edge)
      add(1, 8'h00, 0, 8'h00, 4'h0, 0,   0, 4'h0, 8'hFF);  // 0 reset state
      add(0, 8'hF8, 0, 8'h00, 4'h0, 0,   0, 4'h0, 8'h00);  // 1 pending after reset
      add(0, 8'h00, 0, 8'h00, 4'h0, 0,   0, 4'h0, 8'hFF);
      add(0, 8'hF9, 0, 8'h00, 4'h0, 0,   0, 4'h0, 8'h01);  // 3 initial mask
      add(0, 8'hFA, 0, 8'h00, 4'h0, 0,   0, 4'h0, 8'h00);  // 4 initial vector
      add(0, 8'h00, 0, 8'h00, 4'h1, 0,   0, 4'h0, 8'hFF);  // 5 raise src0
      add(0, 8'h00, 0, 8'h00, 4'h1, 0,   1, 4'h0, 8'hFF);  // 6 irq two edges later
      add(0, 8'hFA, 0, 8'h00, 4'h1, 0,   1, 4'h0, 8'h80);
      add(0, 8'h00, 0, 8'h00, 4'h1, 1,   0, 4'h1, 8'hFF);  // 8 ack to src0
      add(0, 8'h00, 0, 8'h00, 4'h0, 0,   0, 4'h0, 8'hFF);
      add(0, 8'hF8, 0, 8'h00, 4'h0, 0,   0, 4'h0, 8'h00);  // 10 pending cleared
      add(0, 8'h00, 0, 8'h00, 4'h0, 0,   0, 4'h0, 8'hFF);
      add(0, 8'hF9, 1, 8'hFF, 4'h0, 0,   0, 4'h0, 8'hFF);  // 12 mask write, upper bits ignored
      add(0, 8'hF9, 0, 8'h00, 4'h0, 0,   0, 4'h0, 8'h0F);
      add(0, 8'h00, 0, 8'h00, 4'hA, 0,   0, 4'h0, 8'hFF);  // 14 src3 and src1 together
      add(0, 8'h00, 0, 8'h00, 4'hA, 0,   1, 4'h0, 8'hFF);
      add(0, 8'hFA, 0, 8'h00, 4'hA, 0,   1, 4'h0, 8'h81);
      add(0, 8'h00, 0, 8'h00, 4'hA, 1,   0, 4'h2, 8'hFF);
      add(0, 8'h00, 0, 8'h00, 4'h8, 0,   0, 4'h0, 8'hFF);
      add(0, 8'h00, 0, 8'h00, 4'h8, 0,   1, 4'h0, 8'hFF);
      add(0, 8'hFA, 0, 8'h00, 4'h8, 0,   1, 4'h0, 8'h83);  // 20 then src3
      add(0, 8'h00, 0, 8'h00, 4'h8, 1,   0, 4'h8, 8'hFF);
      add(0, 8'h00, 0, 8'h00, 4'h0, 0,   0, 4'h0, 8'hFF);
      add(0, 8'h00, 0, 8'h00, 4'h0, 1,   0, 4'h0, 8'hFF);  // 23 stray cpu ack ignored
      add(0, 8'hF9, 1, 8'h01, 4'h0, 0,   0, 4'h0, 8'hFF);
      add(0, 8'h00, 0, 8'h00, 4'h4, 0,   0, 4'h0, 8'hFF);  // 25 masked src2
      add(0, 8'h00, 0, 8'h00, 4'h4, 0,   0, 4'h0, 8'hFF);
      add(0, 8'hF8, 0, 8'h00, 4'h4, 0,   0, 4'h0, 8'h04);
      add(0, 8'h00, 0, 8'h00, 4'h4, 0,   0, 4'h0, 8'hFF);
      add(0, 8'hF9, 1, 8'h04, 4'h4, 0,   0, 4'h0, 8'hFF);  // 29 selection uses old mask
      add(0, 8'h00, 0, 8'h00, 4'h4, 0,   1, 4'h0, 8'hFF);
      add(0, 8'h00, 0, 8'h00, 4'h4, 1,   0, 4'h4, 8'hFF);
      add(0, 8'h00, 0, 8'h00, 4'h0, 0,   0, 4'h0, 8'hFF);
      add(0, 8'hF9, 1, 8'h00, 4'h0, 0,   0, 4'h0, 8'hFF);
      add(0, 8'h00, 0, 8'h00, 4'h4, 0,   0, 4'h0, 8'hFF);
      add(0, 8'hF8, 1, 8'h04, 4'h4, 0,   0, 4'h0, 8'hFF);  // 35 W1C before enabling
      add(0, 8'hF9, 1, 8'h04, 4'h4, 0,   0, 4'h0, 8'hFF);
      add(0, 8'h00, 0, 8'h00, 4'h4, 0,   0, 4'h0, 8'hFF);
      add(0, 8'hF8, 0, 8'h00, 4'h4, 0,   0, 4'h0, 8'h00);
      add(0, 8'h00, 0, 8'h00, 4'h0, 0,   0, 4'h0, 8'hFF);
      add(0, 8'hF9, 1, 8'h00, 4'h0, 0,   0, 4'h0, 8'hFF);
      add(0, 8'hF8, 1, 8'h04, 4'h4, 0,   0, 4'h0, 8'hFF);  // 41 W1C with new edge: set wins
      add(0, 8'h00, 0, 8'h00, 4'h4, 0,   0, 4'h0, 8'hFF);
      add(0, 8'hF8, 0, 8'h00, 4'h4, 0,   0, 4'h0, 8'h04);
      add(0, 8'h00, 0, 8'h00, 4'h4, 0,   0, 4'h0, 8'hFF);
      add(0, 8'hF8, 1, 8'h04, 4'h0, 0,   0, 4'h0, 8'hFF);
      add(0, 8'hF9, 1, 8'h02, 4'h0, 0,   0, 4'h0, 8'hFF);
      add(0, 8'h00, 0, 8'h00, 4'h2, 0,   0, 4'h0, 8'hFF);
      add(0, 8'h00, 0, 8'h00, 4'h2, 0,   1, 4'h0, 8'hFF);  // 48 asserting idx 1
      add(1, 8'h00, 0, 8'h00, 4'h2, 0,   0, 4'h0, 8'hFF);  // 49 reset mid-assert
      add(0, 8'hF8, 0, 8'h00, 4'h0, 0,   0, 4'h0, 8'h00);
      add(0, 8'h00, 0, 8'h00, 4'h0, 0,   0, 4'h0, 8'hFF);
      add(0, 8'hF9, 0, 8'h00, 4'h0, 0,   0, 4'h0, 8'h01);
      add(0, 8'h00, 0, 8'h00, 4'h0, 0,   0, 4'h0, 8'hFF);
      add(0, 8'hFB, 1, 8'hFF, 4'h0, 0,   0, 4'h0, 8'hFF);  // 54 reserved write ignored
      add(0, 8'hFB, 0, 8'h00, 4'h0, 0,   0, 4'h0, 8'h00);
      add(0, 8'h00, 0, 8'h00, 4'h0, 0,   0, 4'h0, 8'hFF);
      add(0, 8'hF7, 0, 8'h00, 4'h0, 0,   0, 4'h0, 8'hFF);  // 57 below window: undriven
      add(0, 8'hFC, 0, 8'h00, 4'h0, 0,   0, 4'h0, 8'hFF);  // 58 above window: undriven
      add(0, 8'hF9, 0, 8'h00, 4'h0, 0,   0, 4'h0, 8'h01);
      add(0, 8'h00, 0, 8'h00, 4'h0, 0,   0, 4'h0, 8'hFF);
      add(0, 8'h00, 0, 8'h00, 4'h1, 0,   0, 4'h0, 8'hFF);
      add(0, 8'h00, 0, 8'h00, 4'h0, 0,   1, 4'h0, 8'hFF);
      add(0, 8'h00, 0, 8'h00, 4'h0, 1,   0, 4'h1, 8'hFF);
      add(0, 8'h00, 0, 8'h00, 4'h1, 0,   0, 4'h0, 8'hFF);  // 64 edge in ACK cycle
      add(0, 8'h00, 0, 8'h00, 4'h1, 0,   1, 4'h0, 8'hFF);  // 65 still pending -> re-asserts
      add(0, 8'h00, 0, 8'h00, 4'h1, 1,   0, 4'h1, 8'hFF);
      add(0, 8'h00, 0, 8'h00, 4'h0, 0,   0, 4'h0, 8'hFF);
      add(0, 8'h00, 0, 8'h00, 4'h1, 0,   0, 4'h0, 8'hFF);
      add(0, 8'h00, 0, 8'h00, 4'h1, 0,   1, 4'h0, 8'hFF);
      add(0, 8'hF9, 1, 8'h00, 4'h1, 0,   1, 4'h0, 8'hFF);  // 70 mask cleared while asserted
      add(0, 8'hF8, 1, 8'h01, 4'h1, 0,   1, 4'h0, 8'hFF);  // 71 pending cleared while asserted
      add(0, 8'h00, 0, 8'h00, 4'h1, 1,   0, 4'h1, 8'hFF);  // 72 still acknowledged
      add(0, 8'h00, 0, 8'h00, 4'h0, 0,   0, 4'h0, 8'hFF);

      repeat (3) @(posedge CLK);
      @(negedge CLK);

      for (int i = 0; i < vq.size(); i++) begin
         RST              = vq[i].rst;
         if0.BUS_ADDR     = vq[i].addr;
         if0.BUS_WE       = vq[i].we;
         wdata0           = vq[i].wdata;
         drv0             = vq[i].we;
         raise0           = vq[i].raise;
         if0.CPU_IRQ_ACK  = vq[i].cpu_ack;
         @(posedge CLK);
         #1 drv0 = 1'b0;
         @(negedge CLK);
         chk("cpu_irq",  i, 8'(if0.CPU_IRQ), 8'(vq[i].exp_irq));
         chk("src_ack",  i, 8'(ack0),        8'(vq[i].exp_ack));
         chk("bus_data", i, bus_data0,       vq[i].exp_data);
      end
      if0.BUS_ADDR    = '0;
      if0.BUS_WE      = 1'b0;
      if0.CPU_IRQ_ACK = 1'b0;
      raise0          = '0;

      // Rotating priority: every serviced source is re-raised, expected order 0,1,2,3,0.
      order  = '{0, 1, 2, 3, 0};
      raise1 = 4'hF;
      for (int s = 0; s < 5; s++) begin
         n = 0;
         while (if1.CPU_IRQ !== 1'b1 && n < 8) begin
            @(negedge CLK);
            n++;
         end
         chk("rr_irq_wait", s, 8'(if1.CPU_IRQ), 8'h01);
         if1.CPU_IRQ_ACK = 1'b1;
         @(negedge CLK);
         if1.CPU_IRQ_ACK = 1'b0;
         exp_oh = 4'b0001 << order[s];
         chk("rr_src_ack", s, 8'(ack1), 8'(exp_oh));
         chk("rr_irq_low", s, 8'(if1.CPU_IRQ), 8'h00);
         raise1[order[s]] = 1'b0;
         @(negedge CLK);
         chk("rr_ack_clear", s, 8'(ack1), 8'h00);
         raise1[order[s]] = 1'b1;
      end
      raise1 = '0;
      repeat (2) @(negedge CLK);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
